// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared word/address helpers for the CPU memory responder
package mem_resp_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    // Byte address -> word index; the caller truncates to its own index width.
    function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr);
        return addr >> BYTE_OFF_W;
    endfunction

    // True when any address bit at or above the memory's byte span is set.
    function automatic logic out_of_range(input logic [WORD_W-1:0] addr, input int idx_w);
        return (addr >> (idx_w + BYTE_OFF_W)) != '0;
    endfunction

endpackage

// File: rtl/sync_word_ram.sv
// rtl/sync_word_ram.sv - single-port word RAM, registered write-first read, hold on idle
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset of the read register only
//   re, we        read / write strobes (write wins, returns the written word)
//   oor           request is out of range: write dropped, read returns zero
//   idx           word index
//   wdata         write data
//   rdata         registered read data
module sync_word_ram
    import mem_resp_pkg::*;
#(
    parameter int WORDS = 16384,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              we,
    input  logic              oor,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [WORDS];
    logic [WORD_W-1:0] rdata_d, rdata_q;
    logic              mem_we;

    always_comb begin
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        if (we) begin
            if (!oor) begin
                mem_we = 1'b1;
                if (re) rdata_d = wdata;
            end else if (re) begin
                rdata_d = '0;
            end
        end else if (re) begin
            rdata_d = oor ? '0 : mem[idx];
        end
    end

    // Array is never reset; a store landing on an edge while rst is high is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[idx] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - instruction and data memory responder with fault flags and counters
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   instr_read, instr_addr     fetch request; instr_out is the registered fetched word
//   data_read, data_write      load / store strobes (store wins when both high)
//   data_addr, data_in         load/store byte address and store data
//   data_out                   registered load word
//   fault_misalign             sticky: some request had addr[1:0] != 0
//   fault_range                sticky: some request addressed beyond its memory
//   rd_cnt, wr_cnt             saturating counts of accepted loads / stores
module cpu_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int IM_WORDS = 16384,
    parameter int DM_WORDS = 16384,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_read,
    input  logic [WORD_W-1:0] instr_addr,
    output logic [WORD_W-1:0] instr_out,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [WORD_W-1:0] data_addr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              fault_misalign,
    output logic              fault_range,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int IM_IDX_W = $clog2(IM_WORDS);
    localparam int DM_IDX_W = $clog2(DM_WORDS);

    logic [IM_IDX_W-1:0] im_idx;
    logic [DM_IDX_W-1:0] dm_idx;
    logic                im_oor, dm_oor, data_req;

    logic                fault_misalign_d, fault_misalign_q;
    logic                fault_range_d, fault_range_q;
    logic [CNT_W-1:0]    rd_cnt_d, rd_cnt_q;
    logic [CNT_W-1:0]    wr_cnt_d, wr_cnt_q;

    assign im_idx   = IM_IDX_W'(word_index(instr_addr));
    assign dm_idx   = DM_IDX_W'(word_index(data_addr));
    assign im_oor   = out_of_range(instr_addr, IM_IDX_W);
    assign dm_oor   = out_of_range(data_addr, DM_IDX_W);
    assign data_req = data_read | data_write;

    sync_word_ram #(.WORDS(IM_WORDS)) u_im (
        .clk   (clk),
        .rst   (rst),
        .re    (instr_read),
        .we    (1'b0),
        .oor   (im_oor),
        .idx   (im_idx),
        .wdata ('0),
        .rdata (instr_out)
    );

    sync_word_ram #(.WORDS(DM_WORDS)) u_dm (
        .clk   (clk),
        .rst   (rst),
        .re    (data_read),
        .we    (data_write),
        .oor   (dm_oor),
        .idx   (dm_idx),
        .wdata (data_in),
        .rdata (data_out)
    );

    always_comb begin
        fault_misalign_d = fault_misalign_q
                         | (instr_read & (instr_addr[1:0] != 2'b00))
                         | (data_req   & (data_addr[1:0]  != 2'b00));
        fault_range_d    = fault_range_q | (instr_read & im_oor) | (data_req & dm_oor);

        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        // A combined read+write counts only as a store.
        if (data_write && !dm_oor && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        if (data_read && !data_write && !dm_oor && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_misalign_q <= 1'b0;
            fault_range_q    <= 1'b0;
            rd_cnt_q         <= '0;
            wr_cnt_q         <= '0;
        end else begin
            fault_misalign_q <= fault_misalign_d;
            fault_range_q    <= fault_range_d;
            rd_cnt_q         <= rd_cnt_d;
            wr_cnt_q         <= wr_cnt_d;
        end
    end

    assign fault_misalign = fault_misalign_q;
    assign fault_range    = fault_range_q;
    assign rd_cnt         = rd_cnt_q;
    assign wr_cnt         = wr_cnt_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - randomized self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;

    localparam int          CNT_W     = 4;
    localparam int          MAX_CNT   = 15;
    localparam logic [31:0] MEM_BYTES = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_read, data_read, data_write;
    logic [31:0] instr_addr, data_addr, data_in;
    logic [31:0] instr_out, data_out;
    logic        fault_misalign, fault_range;
    logic [CNT_W-1:0] rd_cnt, wr_cnt;

    always #5 clk = ~clk;

    cpu_mem_responder #(.IM_WORDS(16384), .DM_WORDS(16384), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_read     (instr_read),
        .instr_addr     (instr_addr),
        .instr_out      (instr_out),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_addr      (data_addr),
        .data_in        (data_in),
        .data_out       (data_out),
        .fault_misalign (fault_misalign),
        .fault_range    (fault_range),
        .rd_cnt         (rd_cnt),
        .wr_cnt         (wr_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] im_m [int];
    logic [31:0] dm_m [int];
    logic [31:0] e_instr = '0, e_dout = '0;
    logic        e_mis = 1'b0, e_rng = 1'b0;
    int          e_rd = 0, e_wr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".instr_out"}, instr_out, e_instr);
        check({tag, ".data_out"},  data_out,  e_dout);
        check({tag, ".misalign"},  {31'd0, fault_misalign}, {31'd0, e_mis});
        check({tag, ".range"},     {31'd0, fault_range},    {31'd0, e_rng});
        check({tag, ".rd_cnt"},    {28'd0, rd_cnt}, e_rd);
        check({tag, ".wr_cnt"},    {28'd0, wr_cnt}, e_wr);
    endtask

    task automatic model_reset();
        e_instr = '0; e_dout = '0; e_mis = 1'b0; e_rng = 1'b0; e_rd = 0; e_wr = 0;
    endtask

    // Behavioural view: byte address -> word, anything at/above 64 KiB is out of range.
    task automatic model_edge();
        int  ii, di;
        bit  i_oor, d_oor;
        i_oor = instr_addr >= MEM_BYTES;
        d_oor = data_addr  >= MEM_BYTES;
        ii    = int'((instr_addr % MEM_BYTES) / 4);
        di    = int'((data_addr  % MEM_BYTES) / 4);
        if (instr_read) begin
            if (instr_addr % 4 != 0) e_mis = 1'b1;
            if (i_oor) begin e_rng = 1'b1; e_instr = '0; end
            else e_instr = im_m[ii];
        end
        if (data_read || data_write) begin
            if (data_addr % 4 != 0) e_mis = 1'b1;
            if (d_oor) e_rng = 1'b1;
        end
        if (data_write) begin
            if (!d_oor) begin
                dm_m[di] = data_in;
                if (e_wr < MAX_CNT) e_wr++;
                if (data_read) e_dout = data_in;
            end else if (data_read) begin
                e_dout = '0;
            end
        end else if (data_read) begin
            if (d_oor) e_dout = '0;
            else begin
                e_dout = dm_m[di];
                if (e_rd < MAX_CNT) e_rd++;
            end
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] di);
        instr_read = ir; instr_addr = ia; data_read = dr; data_write = dw;
        data_addr = da; data_in = di;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic preload_im(input int idx, input logic [31:0] v);
        im_m[idx] = v;
        dut.u_im.mem[idx] = v;
    endtask

    task automatic preload_dm(input int idx, input logic [31:0] v);
        dm_m[idx] = v;
        dut.u_dm.mem[idx] = v;
    endtask

    // Reset raised between edges while a store is pending; the store must not land.
    task automatic mid_reset();
        logic [31:0] old;
        old = dm_m[16];
        drive(1'b1, 32'h4, 1'b0, 1'b1, 32'h40, ~old);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
        step("post_rst_load");
        check("rst_store_dropped", data_out, old);
        idle();
    endtask

    function automatic logic [31:0] rand_addr();
        int          r, idx;
        logic [31:0] a;
        r   = $urandom_range(0, 99);
        idx = (r < 50) ? $urandom_range(0, 31) : 16352 + $urandom_range(0, 31);
        a   = 32'(idx) << 2;
        if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 11) == 0) a = a | (32'h1 << $urandom_range(16, 31));
        return a;
    endfunction

    initial begin
        idle();
        for (int i = 0; i < 32; i++) begin
            preload_im(i, $urandom);
            preload_dm(i, $urandom);
            preload_im(16352 + i, $urandom);
            preload_dm(16352 + i, $urandom);
        end
        #2 check_all("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Fetch and hold
        preload_im(3, 32'h00A00093);
        drive(1'b1, 32'h0000000C, 1'b0, 1'b0, 32'd0, 32'd0);
        step("fetch");
        check("fetch_word", instr_out, 32'h00A00093);
        drive(1'b0, 32'h00000010, 1'b0, 1'b0, 32'd0, 32'd0);
        step("fetch_hold");
        check("fetch_held", instr_out, 32'h00A00093);

        // Store then load
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        step("store");
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0);
        step("load");
        check("raw_data", data_out, 32'hDEADBEEF);
        check("raw_wr", {28'd0, wr_cnt}, 32'd1);
        check("raw_rd", {28'd0, rd_cnt}, 32'd1);

        // Simultaneous read and write
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        step("rw");
        check("rw_data", data_out, 32'h12345678);
        check("rw_mem", dut.u_dm.mem[8], 32'h12345678);
        check("rw_wr", {28'd0, wr_cnt}, 32'd2);
        check("rw_rd", {28'd0, rd_cnt}, 32'd1);

        // Misaligned load and out-of-range store
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h13, 32'd0);
        step("misalign");
        check("misalign_data", data_out, 32'hDEADBEEF);
        check("misalign_flag", {31'd0, fault_misalign}, 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h00010000, 32'hCAFEF00D);
        step("oor_store");
        check("oor_flag", {31'd0, fault_range}, 32'd1);
        check("oor_wr", {28'd0, wr_cnt}, 32'd2);
        check("oor_mem", dut.u_dm.mem[0], dm_m[0]);
        idle();
        for (int i = 0; i < 3; i++) step("idle");
        check("sticky_mis", {31'd0, fault_misalign}, 32'd1);
        check("sticky_rng", {31'd0, fault_range}, 32'd1);

        mid_reset();
        check("rst_cleared_mis", {31'd0, fault_misalign}, 32'd0);

        // Saturation
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, 32'($urandom_range(0, 31)) << 2, 32'd0);
            step("sat");
        end
        check("rd_saturated", {28'd0, rd_cnt}, 32'hF);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                mid_reset();
            end else begin
                drive($urandom_range(0, 1), rand_addr(), $urandom_range(0, 1),
                      $urandom_range(0, 2) == 0, rand_addr(), $urandom);
                step("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
